led_pattern_rot: RTL and testbench

- Parametrised successor to the single-pattern LED rotator: drives a WIDTH-bit LED pattern that advances once every DIV clocks.
- Modes: rotate-left, rotate-right, bounce (one-hot "scanner") and hold.
- Adds enable, seed load and a step strobe.
- Sits directly on board LED pins, or feeds a status bar, in hx8k demo tops.

---
 rtl/led_pattern_rot.sv | 112 +++++++++++
 tb/tb_led_pattern_rot.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_rot.sv
// rtl/led_pattern_rot.sv - prescaled LED pattern rotator/bounce scanner; optional PWM dimming under LED_PWM_EN
module led_pattern_rot #(
    parameter int WIDTH = 4,
    parameter int DIV   = 12000000,
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
`ifdef LED_PWM_EN
    input  logic [7:0]       duty,
`endif
    output logic [WIDTH-1:0] led,
    output logic             step,
    output logic             dir
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] rot_l;
    logic [WIDTH-1:0] rot_r;
    logic [WIDTH-1:0] next_pattern;
    logic             next_dir;
    logic             tick;

    // Last enabled clock of a prescaler period; the new pattern lands on the following edge.
    assign tick = en && (cnt == CNT_LAST);

    // Rotations written as index maps so WIDTH=1 degenerates to identity without zero-width slices.
    always_comb begin
        rot_l = '0;
        rot_r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rot_l[i] = pattern[(i + WIDTH - 1) % WIDTH];
            rot_r[i] = pattern[(i + 1) % WIDTH];
        end
    end

    // Next pattern/direction for a tick; bounce turns around on the end bit only, shifted-out bits are lost.
    always_comb begin
        next_pattern = pattern;
        next_dir     = dir;
        case (mode)
            2'b00: next_pattern = rot_l;
            2'b01: next_pattern = rot_r;
            2'b10: begin
                if (WIDTH > 1) begin
                    if (!dir && pattern[WIDTH-1]) begin
                        next_dir     = 1'b1;
                        next_pattern = pattern >> 1;
                    end else if (dir && pattern[0]) begin
                        next_dir     = 1'b0;
                        next_pattern = pattern << 1;
                    end else if (dir) begin
                        next_pattern = pattern >> 1;
                    end else begin
                        next_pattern = pattern << 1;
                    end
                end
            end
            default: next_pattern = pattern;
        endcase
    end

    // Pattern state and prescaler: reset beats load, load beats a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= WIDTH'(1);
            cnt     <= '0;
            dir     <= 1'b0;
            step    <= 1'b0;
        end else if (load) begin
            pattern <= seed;
            cnt     <= '0;
            dir     <= 1'b0;
            step    <= 1'b0;
        end else if (tick) begin
            pattern <= next_pattern;
            dir     <= next_dir;
            cnt     <= '0;
            step    <= 1'b1;
        end else begin
            if (en) begin
                cnt <= cnt + CNT_W'(1);
            end
            step <= 1'b0;
        end
    end

`ifdef LED_PWM_EN
    logic [7:0] pwm_cnt;

    // Free-running PWM phase; the masked pattern is re-registered, adding one clock on led only.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= 8'd0;
            led     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            led     <= pattern & {WIDTH{pwm_cnt < duty}};
        end
    end
`else
    assign led = pattern;
`endif

endmodule

// File: tb/tb_led_pattern_rot.sv
// tb/tb_led_pattern_rot.sv - self-checking bench for led_pattern_rot
module tb_led_pattern_rot;

    localparam int W    = 4;
    localparam int D    = 4;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, en, load;
    logic [1:0]   mode;
    logic [W-1:0] seed;
    logic [W-1:0] led;
    logic         step, dir;

    logic         rst1, en1, load1, seed1;
    logic [1:0]   mode1;
    logic         led1, step1, dir1;

    int checks = 0;
    int errors = 0;

    int m_led;
    int m_cnt;
    bit m_dir;
    bit m_step;

    typedef struct {
        bit         do_rst;
        logic [1:0] mode;
        logic [3:0] exp_led;
        bit         exp_dir;
    } vec_t;

    vec_t vecs[$];

    led_pattern_rot #(.WIDTH(W), .DIV(D), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .seed(seed),
        .led(led), .step(step), .dir(dir)
    );

    led_pattern_rot #(.WIDTH(1), .DIV(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .mode(mode1), .load(load1), .seed(seed1),
        .led(led1), .step(step1), .dir(dir1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void next_pat(input int p, input int md, input bit d, output int np, output bit nd);
        int top;
        nd  = d;
        np  = p;
        top = (p >> (W - 1)) & 1;
        case (md)
            0: np = ((p << 1) | (p >> (W - 1))) & MASK;
            1: np = ((p >> 1) | ((p & 1) << (W - 1))) & MASK;
            2: begin
                if (!d && top == 1) begin
                    nd = 1; np = p >> 1;
                end else if (d && (p & 1) == 1) begin
                    nd = 0; np = (p << 1) & MASK;
                end else begin
                    np = d ? (p >> 1) : ((p << 1) & MASK);
                end
            end
            default: np = p;
        endcase
    endfunction

    // Reference: count enabled cycles since the last step/load; the D-th one produces a step.
    task automatic model_clock();
        int np;
        bit nd;
        if (rst) begin
            m_led = 1; m_cnt = 0; m_dir = 0; m_step = 0;
        end else if (load) begin
            m_led = int'(seed); m_cnt = 0; m_dir = 0; m_step = 0;
        end else if (!en) begin
            m_step = 0;
        end else begin
            m_cnt++;
            if (m_cnt == D) begin
                next_pat(m_led, int'(mode), m_dir, np, nd);
                m_led = np; m_dir = nd; m_cnt = 0; m_step = 1;
            end else begin
                m_step = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        chk("model_led", 32'(led), 32'(m_led));
        chk("model_step", 32'(step), 32'(m_step));
        chk("model_dir", 32'(dir), 32'(m_dir));
    endtask

    task automatic do_reset();
        rst = 1; en = 0; load = 0;
        repeat (3) begin
            cycle();
            chk("rst_led", 32'(led), 32'd1);
            chk("rst_step", 32'(step), 32'd0);
            chk("rst_dir", 32'(dir), 32'd0);
        end
        rst = 0;
    endtask

    initial begin
        logic [3:0] prev_exp;

        rst = 1; en = 0; load = 0; mode = 2'b00; seed = '0;
        rst1 = 1; en1 = 1; load1 = 0; seed1 = 0; mode1 = 2'b00;

        vecs.push_back(vec_t'{1'b1, 2'b00, 4'b0010, 1'b0});
        vecs.push_back(vec_t'{1'b0, 2'b00, 4'b0100, 1'b0});
        vecs.push_back(vec_t'{1'b0, 2'b00, 4'b1000, 1'b0});
        vecs.push_back(vec_t'{1'b0, 2'b00, 4'b0001, 1'b0});
        vecs.push_back(vec_t'{1'b1, 2'b01, 4'b1000, 1'b0});
        vecs.push_back(vec_t'{1'b0, 2'b01, 4'b0100, 1'b0});
        vecs.push_back(vec_t'{1'b0, 2'b01, 4'b0010, 1'b0});
        vecs.push_back(vec_t'{1'b0, 2'b01, 4'b0001, 1'b0});
        vecs.push_back(vec_t'{1'b1, 2'b10, 4'b0010, 1'b0});
        vecs.push_back(vec_t'{1'b0, 2'b10, 4'b0100, 1'b0});
        vecs.push_back(vec_t'{1'b0, 2'b10, 4'b1000, 1'b0});
        vecs.push_back(vec_t'{1'b0, 2'b10, 4'b0100, 1'b1});
        vecs.push_back(vec_t'{1'b0, 2'b10, 4'b0010, 1'b1});
        vecs.push_back(vec_t'{1'b0, 2'b10, 4'b0001, 1'b1});
        vecs.push_back(vec_t'{1'b0, 2'b10, 4'b0010, 1'b0});
        vecs.push_back(vec_t'{1'b0, 2'b11, 4'b0010, 1'b0});
        vecs.push_back(vec_t'{1'b0, 2'b11, 4'b0010, 1'b0});

        prev_exp = 4'b0001;
        foreach (vecs[k]) begin
            if (vecs[k].do_rst) begin
                do_reset();
                prev_exp = 4'b0001;
            end
            mode = vecs[k].mode;
            en   = 1;
            for (int c = 1; c <= D; c++) begin
                cycle();
                if (c < D) begin
                    chk("tbl_hold_led", 32'(led), 32'(prev_exp));
                    chk("tbl_nostep", 32'(step), 32'd0);
                end else begin
                    chk("tbl_led", 32'(led), 32'(vecs[k].exp_led));
                    chk("tbl_step", 32'(step), 32'd1);
                    chk("tbl_dir", 32'(dir), 32'(vecs[k].exp_dir));
                end
            end
            prev_exp = vecs[k].exp_led;
        end

        // Freeze mid-count at cnt=2, then resume: step arrives two enabled clocks later.
        do_reset();
        chk("w1_rst_led", 32'(led1), 32'd1);
        chk("w1_rst_step", 32'(step1), 32'd0);
        mode = 2'b00; en = 1;
        cycle(); cycle();
        en = 0;
        repeat (10) begin
            cycle();
            chk("frz_led", 32'(led), 32'd1);
            chk("frz_step", 32'(step), 32'd0);
        end
        en = 1;
        cycle();
        chk("resume1_step", 32'(step), 32'd0);
        cycle();
        chk("resume2_step", 32'(step), 32'd1);
        chk("resume2_led", 32'(led), 32'b0010);

        // Load on the tick cycle discards the tick.
        cycle(); cycle(); cycle();
        load = 1; seed = 4'b1010;
        cycle();
        chk("load_led", 32'(led), 32'b1010);
        chk("load_step", 32'(step), 32'd0);
        load = 0;
        for (int c = 1; c <= D; c++) begin
            cycle();
            chk("postload_step", 32'(step), (c == D) ? 32'd1 : 32'd0);
        end
        chk("postload_led", 32'(led), 32'b0101);

        // Reset mid-count discards the partial count.
        cycle(); cycle();
        rst = 1;
        cycle();
        chk("rstmid_led", 32'(led), 32'd1);
        rst = 0;
        for (int c = 1; c <= D; c++) begin
            cycle();
            chk("rstmid_step", 32'(step), (c == D) ? 32'd1 : 32'd0);
        end
        chk("rstmid_led2", 32'(led), 32'b0010);

        // Mode change between ticks takes effect at the next tick.
        mode = 2'b11;
        cycle(); cycle();
        mode = 2'b00;
        cycle();
        chk("modesw_nostep", 32'(step), 32'd0);
        cycle();
        chk("modesw_step", 32'(step), 32'd1);
        chk("modesw_led", 32'(led), 32'b0100);

        // All-zero seed in bounce stays zero and never flips dir.
        load = 1; seed = 4'b0000; mode = 2'b10;
        cycle();
        load = 0;
        repeat (12) begin
            cycle();
            chk("zero_led", 32'(led), 32'd0);
            chk("zero_dir", 32'(dir), 32'd0);
        end

        // Multi-bit seed: turnaround looks only at the end bit; shifted-out bits are lost.
        load = 1; seed = 4'b1001;
        cycle();
        load = 0;
        repeat (D) cycle();
        chk("multi_led", 32'(led), 32'b0100);
        chk("multi_dir", 32'(dir), 32'd1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom % 64) == 0;
            load = ($urandom % 16) == 0;
            en   = ($urandom % 4) != 0;
            mode = 2'($urandom);
            seed = W'($urandom);
            cycle();
        end
        rst = 0; load = 0;

        // WIDTH=1, DIV=1: led stays 1, step every enabled cycle in every mode.
        rst1 = 0;
        for (int c = 0; c < 8; c++) begin
            mode1 = 2'(c);
            cycle();
            chk("w1_led", 32'(led1), 32'd1);
            chk("w1_step", 32'(step1), 32'd1);
            chk("w1_dir", 32'(dir1), 32'd0);
        end
        en1 = 0;
        cycle();
        chk("w1_off_step", 32'(step1), 32'd0);
        chk("w1_off_led", 32'(led1), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
